// File: rtl/vector_test_sequencer.sv
// Self-test controller that sweeps every input of a small combinational function, compares each
// response with a golden truth table, and reports an error count, the first failing vector and a verdict.
module vector_test_sequencer #(
  parameter int unsigned           N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = 16'h0000,
  parameter int unsigned           SETTLE   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     errors,
  output logic              fail_valid,
  output logic [N_IN-1:0]   fail_vec
);

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e          state_q;
  logic [N_IN-1:0] idx_q;
  logic [3:0]      cnt_q;
  logic [N_IN:0]   errors_q;
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            mismatch;
  logic            last_vec;

  assign mismatch = (dut_y != EXPECTED[idx_q]);
  assign last_vec = &idx_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      errors_q     <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // A start from DONE discards the previous run's results.
          if (start) begin
            state_q      <= StSettle;
            idx_q        <= '0;
            cnt_q        <= SettleCnt;
            errors_q     <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        StSettle: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (mismatch) begin
            errors_q <= errors_q + (N_IN+1)'(1);
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= idx_q;
            end
          end
          // Stop at the last vector rather than letting idx wrap back to 0.
          if (last_vec) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errors_q == '0) && !mismatch;
          end else begin
            state_q <= StSettle;
            idx_q   <= idx_q + N_IN'(1);
            cnt_q   <= SettleCnt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dut_in     = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign errors     = errors_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_vector_test_sequencer.sv
// Bench for vector_test_sequencer: table-driven runs on a SETTLE=1 instance, plus hand sequences
// for SETTLE=0 with an ignored start, a mid-run reset and restart from DONE.
module tb_vector_test_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, start0;
  logic [3:0] dut_in, dut_in0;
  logic       dut_y, dut_y0;
  logic       busy, done, pass, fail_valid;
  logic       busy0, done0, pass0, fail_valid0;
  logic [4:0] errors, errors0;
  logic [3:0] fail_vec, fail_vec0;

  logic [15:0] golden = 16'hA5C3;
  int          mode, mode0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    int mode;
    int exp_err;
    bit exp_fv;
    int exp_fvec;
    bit exp_pass;
  } run_t;

  run_t tbl[4];
  run_t sb[$];

  always #5 clk = ~clk;

  // Function under test: mode 0 correct, 1 wrong only at input 5, 2 wrong everywhere.
  assign dut_y  = golden[dut_in]  ^ ((mode == 2)  || (mode == 1  && dut_in == 4'd5));
  assign dut_y0 = golden[dut_in0] ^ ((mode0 == 2) || (mode0 == 1 && dut_in0 == 4'd5));

  vector_test_sequencer #(.N_IN(4), .EXPECTED(16'hA5C3), .SETTLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dut_in(dut_in), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .errors(errors),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  vector_test_sequencer #(.N_IN(4), .EXPECTED(16'hA5C3), .SETTLE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .dut_in(dut_in0), .dut_y(dut_y0),
    .busy(busy0), .done(done0), .pass(pass0), .errors(errors0),
    .fail_valid(fail_valid0), .fail_vec(fail_vec0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_results(input string tag, input run_t e);
    chk({tag, "_errors"}, 32'(errors), 32'(e.exp_err));
    chk({tag, "_fail_valid"}, 32'(fail_valid), 32'(e.exp_fv));
    if (e.exp_fv) chk({tag, "_fail_vec"}, 32'(fail_vec), 32'(e.exp_fvec));
    chk({tag, "_pass"}, 32'(pass), 32'(e.exp_pass));
  endtask

  // Full run on the SETTLE=1 instance: 3 cycles per vector, done at E48.
  task automatic run_main(input run_t r);
    run_t e;
    mode = r.mode;
    @(posedge clk); #1 start = 1'b1;
    sb.push_back(r);
    @(posedge clk); #1 start = 1'b0;  // E0 has been sampled
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("start_clears_errors", 32'(errors), 32'd0);
        chk("start_clears_fail_valid", 32'(fail_valid), 32'd0);
        chk("start_clears_done_pass", {30'd0, done, pass}, 32'd0);
      end
      chk("busy_dut_in_step", {27'd0, done, busy, dut_in}, {27'd0, 1'b0, 1'b1, 4'(c / 3)});
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_at_48", {30'd0, done, busy}, 32'b10);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_results("run", e);
      repeat (3) @(negedge clk);
      chk("done_held", 32'(done), 32'd1);
      check_results("held", e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    run_t r0;
    tbl[0] = '{mode: 0, exp_err: 0,  exp_fv: 1'b0, exp_fvec: 0, exp_pass: 1'b1};
    tbl[1] = '{mode: 1, exp_err: 1,  exp_fv: 1'b1, exp_fvec: 5, exp_pass: 1'b0};
    tbl[2] = '{mode: 2, exp_err: 16, exp_fv: 1'b1, exp_fvec: 0, exp_pass: 1'b0};
    tbl[3] = '{mode: 0, exp_err: 0,  exp_fv: 1'b0, exp_fvec: 0, exp_pass: 1'b1};  // restart from DONE

    reset_n = 1'b0; start = 1'b0; start0 = 1'b0; mode = 0; mode0 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {18'd0, busy, done, pass, fail_valid, errors, fail_vec},  32'd0);
    chk("reset_dut_in", 32'(dut_in), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) run_main(tbl[i]);

    // SETTLE=0: 2 cycles per vector; a start pulse at cycle 10 must be ignored.
    mode0 = 1;
    r0 = '{mode: 1, exp_err: 1, exp_fv: 1'b1, exp_fvec: 5, exp_pass: 1'b0};
    @(posedge clk); #1 start0 = 1'b1;
    sb.push_back(r0);
    @(posedge clk); #1 start0 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 10) start0 = 1'b1;
      if (c == 11) start0 = 1'b0;
      chk("s0_busy_dut_in", {26'd0, done0, busy0, dut_in0}, {26'd0, 1'b0, 1'b1, 4'(c / 2)});
      @(posedge clk);
    end
    @(negedge clk);
    chk("s0_done_at_32", {30'd0, done0, busy0}, 32'b10);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      r0 = sb.pop_front();
      chk("s0_errors", 32'(errors0), 32'(r0.exp_err));
      chk("s0_fail_vec", {27'd0, fail_valid0, fail_vec0}, {27'd0, 1'b1, 4'(r0.exp_fvec)});
      chk("s0_pass", 32'(pass0), 32'(r0.exp_pass));
    end

    // Reset at cycle 20 of an all-fault run; six CHECKs have completed by then.
    mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 20; c++) @(posedge clk);
    @(negedge clk);
    chk("midrun_errors", 32'(errors), 32'd6);
    chk("midrun_fail", {27'd0, fail_valid, fail_vec}, {27'd0, 1'b1, 4'd0});
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("after_reset_outputs", {18'd0, busy, done, pass, fail_valid, errors, fail_vec}, 32'd0);
    chk("after_reset_dut_in", 32'(dut_in), 32'd0);
    chk("after_reset_dut0", {14'd0, busy0, done0, pass0, fail_valid0, errors0, fail_vec0, dut_in0},
        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_test_sequencer.md
# vector_test_sequencer

Built-in self-test controller that exhaustively drives a small combinational function (an N_IN-input, 1-output logic block) through all 2^N_IN input combinations. It compares each response against a golden truth table held as a parameter and reports an error count, the first failing vector, and a pass/fail verdict. It replaces file-driven testbench stimulus with synthesizable hardware, so the same check can run on silicon or an FPGA.

## Interface
Parameters:
- N_IN, 4: width of the function's input bus. N_VEC = 2^N_IN is derived internally.
- EXPECTED, 16'h0000: golden truth table, N_VEC bits. Bit i is the expected y when the function input equals i.
- SETTLE, 1: number of wait cycles after applying a vector before sampling y. Range 0..15.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- start, input, 1: begin a test run. Sampled only in IDLE or DONE.
- dut_in, output, N_IN: registered input vector driven to the function under test.
- dut_y, input, 1: response of the function under test.
- busy, output, 1: high in SETTLE and CHECK.
- done, output, 1: high in DONE (level).
- pass, output, 1: in DONE, equals (errors == 0); 0 in all other states.
- errors, output, N_IN+1: mismatch count for the current or last run.
- fail_valid, output, 1: at least one mismatch recorded in this run.
- fail_vec, output, N_IN: index of the first mismatching vector. Meaningful only when fail_valid = 1.

## Operation
States: IDLE, SETTLE, CHECK, DONE.

- **IDLE**
  - start = 1: idx <= 0, cnt <= SETTLE, errors <= 0, fail_valid <= 0, fail_vec <= 0; go to SETTLE.
  - Otherwise stay.
- **SETTLE**
  - cnt != 0: cnt <= cnt - 1.
  - cnt == 0: go to CHECK.
  - dut_in = idx throughout.
- **CHECK**
  - Sample dut_y and compare with EXPECTED[idx].
  - On mismatch: errors <= errors + 1. If fail_valid = 0, also fail_vec <= idx and fail_valid <= 1.
  - If idx == N_VEC-1: go to DONE.
  - Otherwise: idx <= idx + 1, cnt <= SETTLE, go to SETTLE.
- **DONE**
  - Hold all results.
  - start = 1: restart exactly as from IDLE, clearing errors and fail_valid/fail_vec.
- start while busy = 1 is ignored and has no effect.
- dut_in is a register equal to idx. It changes only on the edge that leaves CHECK, or when a run starts (idx cleared to 0).
- errors cannot overflow: its maximum is N_VEC, which fits in N_IN+1 bits. No saturation logic is required.
- idx must not wrap. The run ends at N_VEC-1 and never re-applies vector 0 within a run.

## Timing
- **Reset:** reset_n low at a rising edge forces IDLE and clears all outputs and internal state on that edge.
  - dut_in = 0, busy = 0, done = 0, pass = 0, errors = 0, fail_valid = 0, fail_vec = 0.
  - Reset mid-run aborts the run with no partial results retained.
- **Run start:** start sampled high at edge E0 puts the block in SETTLE from E0 onward, with dut_in = 0.
- **Per-vector cost:** SETTLE+2 cycles (SETTLE+1 in the SETTLE state, 1 in CHECK).
- **Sampling point:** dut_y is sampled at the edge that ends CHECK. The function therefore has at least SETTLE+1 full cycles of stable dut_in before sampling.
- **Run end:** done rises, and busy falls, N_VEC*(SETTLE+2) cycles after E0. For defaults this is 48 cycles (edge E48).
- **Visibility:** errors and fail_* update on the edge ending the CHECK in which the mismatch occurred, and are visible on the following cycle.
- **Handshake:** no handshake on dut_y. The block assumes the function is purely combinational with delay shorter than SETTLE+1 cycles.

## Test plan
- **All-pass run:** EXPECTED = 16'hA5C3, bench function y = EXPECTED[dut_in], pulse start.
  - Required: busy for 48 cycles, then done = 1, pass = 1, errors = 0, fail_valid = 0.
  - dut_in steps 0..15, each held 3 cycles.
- **Single fault:** same setup, but the bench inverts y only when dut_in = 5.
  - Required: errors = 1, fail_valid = 1, fail_vec = 5, pass = 0.
- **All faults:** the bench drives y = ~EXPECTED[dut_in].
  - Required: errors = 16, fail_vec = 0, pass = 0.
- **SETTLE = 0 with start while busy:** use SETTLE = 0, pulse start again at cycle 10.
  - Required: the second pulse is ignored, and done rises exactly 32 cycles after the first start.
- **Reset mid-run:** assert reset_n = 0 at cycle 20 of a run that has errors, release it, wait 5 cycles.
  - Required: IDLE, with all outputs 0 and dut_in = 0.
- **Restart from DONE:** after a failing run, pulse start with a fault-free function.
  - Required: errors and fail_valid clear on the start edge, and the final result is pass = 1.
